// File: rtl/freq_gate_pkg.sv
// Shared types and constants for the gated frequency counter controller.
// Optional feature macro: FREQ_GATE_CONT_EN (continuous back-to-back measurement).
package freq_gate_pkg;

    // Width of the external edge counter and of the captured result.
    localparam int unsigned CNT_W = 32;

    // Count value the external counter saturates at.
    localparam logic [CNT_W-1:0] CNT_SAT = 32'hFFFF_FFFF;

    // Measurement sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        GATE,
        SETTLE,
        CAPTURE
    } state_t;

    // True when a captured count has hit the saturation value.
    function automatic logic is_sat(input logic [CNT_W-1:0] value);
        return value == CNT_SAT;
    endfunction

endpackage

// File: rtl/freq_gate_ctrl_if.sv
// Handshake/bus bundle between the measurement controller and its
// surroundings (edge counter and result consumer).
// Optional feature macro: FREQ_GATE_CONT_EN adds the cont request line.
interface freq_gate_ctrl_if;
    import freq_gate_pkg::*;

    logic             start;         // request one measurement
`ifdef FREQ_GATE_CONT_EN
    logic             cont;          // keep measuring back-to-back
`endif
    logic [CNT_W-1:0] cnt_val;       // live value of the external edge counter
    logic             cnt_clr;       // clear strobe to the edge counter
    logic             cnt_en;        // gate enable to the edge counter
    logic [CNT_W-1:0] result;        // captured edge count
    logic             result_valid;  // result not yet acknowledged
    logic             result_ack;    // consumer acknowledge
    logic             busy;          // measurement in progress
    logic             overflow;      // captured count was saturated
    logic             overrun;       // sticky: unacknowledged result replaced

`ifdef FREQ_GATE_CONT_EN
    modport master (
        output start, cont, cnt_val, result_ack,
        input  cnt_clr, cnt_en, result, result_valid, busy, overflow, overrun
    );
    modport slave (
        input  start, cont, cnt_val, result_ack,
        output cnt_clr, cnt_en, result, result_valid, busy, overflow, overrun
    );
`else
    modport master (
        output start, cnt_val, result_ack,
        input  cnt_clr, cnt_en, result, result_valid, busy, overflow, overrun
    );
    modport slave (
        input  start, cnt_val, result_ack,
        output cnt_clr, cnt_en, result, result_valid, busy, overflow, overrun
    );
`endif

endinterface

// File: rtl/freq_gate_ctrl_gate_timer.sv
// Down-counter shared by the gate and settle phases. Load takes priority
// over decrement; done is high whenever the count has reached zero.
// Optional feature macro: FREQ_GATE_CONT_EN (not used in this file).
module gate_timer
    import freq_gate_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             done_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: load, else decrement towards zero, else hold.
    always_comb begin
        // NOTE: default assignment first so every path drives count_d and no latch is inferred.
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/freq_gate_ctrl.sv
// Gated frequency measurement controller: clears the external edge counter,
// opens the gate for GATE_CYCLES, waits SETTLE_CYCLES, then captures the
// count into a valid/ack result register with overflow and overrun flags.
// Optional feature macro: FREQ_GATE_CONT_EN adds bus.cont; when high,
// CAPTURE chains straight into the next CLEAR without a new start.
module freq_gate_ctrl
    import freq_gate_pkg::*;
#(
    parameter int unsigned GATE_CYCLES   = 50_000_000,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic             clock,
    input  logic             reset,
    freq_gate_ctrl_if.slave  bus
);

    // Timer reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [CNT_W-1:0] GATE_LOAD   = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state_q;
    logic             cnt_clr_q;
    logic             cnt_en_q;
    logic             busy_q;
    logic [CNT_W-1:0] result_q;
    logic             result_valid_q;
    logic             overflow_q;
    logic             overrun_q;

    logic             timer_load;
    logic [CNT_W-1:0] timer_val;
    logic             timer_dec;
    logic             timer_done;
    logic             ack_taken;
    logic             chain;

    gate_timer u_gate_timer (
        .clock      (clock),
        .reset      (reset),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .dec_i      (timer_dec),
        .done_o     (timer_done)
    );

    // An acknowledge only counts when there is a result to acknowledge.
    assign ack_taken = bus.result_ack && result_valid_q;

`ifdef FREQ_GATE_CONT_EN
    assign chain = bus.cont;
`else
    assign chain = 1'b0;
`endif

    // Timer control: load the gate length in CLEAR, the settle length on
    // the last gate cycle, and count down inside each phase.
    always_comb begin
        timer_load = 1'b0;
        timer_val  = '0;
        timer_dec  = 1'b0;
        unique case (state_q)
            CLEAR: begin
                timer_load = 1'b1;
                timer_val  = GATE_LOAD;
            end
            GATE: begin
                if (timer_done) begin
                    timer_load = 1'b1;
                    timer_val  = SETTLE_LOAD;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            SETTLE: begin
                timer_dec = !timer_done;
            end
            default: begin
            end
        endcase
    end

    // Sequencer with registered strobes, plus the result/valid/overrun
    // bookkeeping driven by CAPTURE and the consumer acknowledge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            cnt_clr_q      <= 1'b0;
            cnt_en_q       <= 1'b0;
            busy_q         <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q   <= CLEAR;
                        cnt_clr_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                CLEAR: begin
                    state_q   <= GATE;
                    cnt_clr_q <= 1'b0;
                    cnt_en_q  <= 1'b1;
                end
                GATE: begin
                    if (timer_done) begin
                        state_q  <= SETTLE;
                        cnt_en_q <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (timer_done) begin
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (chain) begin
                        state_q   <= CLEAR;
                        cnt_clr_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    cnt_clr_q <= 1'b0;
                    cnt_en_q  <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase

            // A capture beats a simultaneous acknowledge: the new result
            // stays valid, and only an unacknowledged old result is lost.
            if (state_q == CAPTURE) begin
                result_q       <= bus.cnt_val;
                overflow_q     <= is_sat(bus.cnt_val);
                result_valid_q <= 1'b1;
                if (result_valid_q && !bus.result_ack) begin
                    overrun_q <= 1'b1;
                end else if (ack_taken) begin
                    overrun_q <= 1'b0;
                end
            end else if (ack_taken) begin
                result_valid_q <= 1'b0;
                overrun_q      <= 1'b0;
            end
        end
    end

    assign bus.cnt_clr      = cnt_clr_q;
    assign bus.cnt_en       = cnt_en_q;
    assign bus.busy         = busy_q;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.overflow     = overflow_q;
    assign bus.overrun      = overrun_q;

endmodule

// File: doc/freq_gate_ctrl.md
FREQ_GATE_CTRL -- requirements
Module: freq_gate_ctrl

Interface
REQ-001 The block SHALL have parameter GATE_CYCLES, default 50000000, gate window length in clock cycles (legal range 1..2^32-1).
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 4, cycles waited after the gate closes before capture (legal range 1..255).
REQ-003 The block SHALL have port clock, input, 1, system timebase.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, request for one measurement; sampled only in IDLE.
REQ-006 The block SHALL have port cnt_val, input, 32, current value of the external edge counter.
REQ-007 The block SHALL have port cnt_clr, output, 1, synchronous clear strobe to the edge counter.
REQ-008 The block SHALL have port cnt_en, output, 1, gate enable to the edge counter.
REQ-009 The block SHALL have port result, output, 32, captured edge count.
REQ-010 The block SHALL have port result_valid, output, 1, result holds an unacknowledged capture.
REQ-011 The block SHALL have port result_ack, input, 1, consumer acknowledge.
REQ-012 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-013 The block SHALL have port overflow, output, 1, captured count equalled 32'hFFFFFFFF (saturated).
REQ-014 The block SHALL have port overrun, output, 1, sticky: a capture replaced an unacknowledged result.

Function
REQ-015 FSM states SHALL be IDLE, CLEAR, GATE, SETTLE, CAPTURE.
REQ-016 IDLE SHALL go to CLEAR on the cycle after start=1 is sampled; start in any other state SHALL be ignored.
REQ-017 CLEAR SHALL last exactly 1 cycle with cnt_clr=1 and cnt_en=0, then go to GATE.
REQ-018 GATE SHALL last exactly GATE_CYCLES cycles with cnt_en=1, timed by a down-counter loaded with GATE_CYCLES-1 on CLEAR.
REQ-019 SETTLE SHALL last exactly SETTLE_CYCLES cycles with cnt_en=0 and cnt_clr=0.
REQ-020 CAPTURE SHALL last 1 cycle; result<=cnt_val, overflow<=(cnt_val==32'hFFFFFFFF), result_valid<=1, all registered so visible the following cycle.
REQ-021 CAPTURE SHALL return to IDLE (continuous mode: see REQ-029).
REQ-022 result_valid SHALL clear on the cycle after result_ack=1 is sampled while result_valid=1; result_ack with result_valid=0 SHALL have no effect.
REQ-023 result_ack and a CAPTURE in the same cycle SHALL leave result_valid=1 with the new result (capture wins).
REQ-024 CAPTURE while result_valid=1 and no ack that cycle SHALL overwrite result and set overrun; overrun SHALL clear only on an accepted ack.
REQ-025 result, overflow SHALL hold their value until the next CAPTURE.
REQ-026 Start-to-result_valid latency SHALL be 1+1+GATE_CYCLES+SETTLE_CYCLES+1 cycles.

Reset
REQ-027 reset=0 SHALL asynchronously force state IDLE, gate/settle counters 0, cnt_clr=0, cnt_en=0, result=0, result_valid=0, busy=0, overflow=0, overrun=0, including mid-measurement; no partial result SHALL be produced.
REQ-028 After reset release, the first start SHALL be honoured on the first rising clock edge.

Configuration
REQ-029 With FREQ_GATE_CONT_EN defined, a port cont (input, 1) SHALL exist; CAPTURE with cont=1 SHALL go to CLEAR instead of IDLE, giving back-to-back measurements with no start.
REQ-030 Without FREQ_GATE_CONT_EN, the cont port SHALL not exist and CAPTURE SHALL always go to IDLE.

Structure
REQ-031 Package freq_gate_pkg SHALL hold the state enum, the 32-bit count width constant, and the saturation value 32'hFFFFFFFF.
REQ-032 The gate/settle down-counter SHALL be sub-module gate_timer (load, value, decrement, done flag); the FSM SHALL stay in freq_gate_ctrl.

Verification (GATE_CYCLES=10, SETTLE_CYCLES=2)
REQ-033 Start pulse, cnt_val driven to 37 by the model -> cnt_clr 1 cycle, cnt_en high exactly 10 cycles, result_valid after 15 cycles, result=37.
REQ-034 cnt_val=32'hFFFFFFFF at capture -> result=32'hFFFFFFFF, overflow=1; next measurement with 5 -> overflow=0.
REQ-035 Two measurements, no ack between -> second result present, overrun=1; ack -> result_valid=0, overrun=0 the next cycle.
REQ-036 reset=0 asserted on gate cycle 6 -> cnt_en=0 and busy=0 immediately, result_valid stays 0; start after release -> full 15-cycle measurement.
REQ-037 start held high through a measurement -> extra starts ignored while busy; with FREQ_GATE_CONT_EN and cont=1 -> CLEAR follows CAPTURE directly, results every 14 cycles.
